// File: rtl/mips_test_harness.sv
// Bring-up harness for the pipelined MIPS32 core: loads a program, seeds registers,
// clears and runs the core, then streams R0..R(DUMP_COUNT-1) out on a valid/ready port.
module mips_test_harness #(
    parameter int DATA_W         = 32,
    parameter int PROG_DEPTH     = 16,
    parameter int PADDR_W        = 4,
    parameter int REG_COUNT      = 32,
    parameter int RADDR_W        = 5,
    parameter int INIT_REGS      = 1,
    parameter int DUMP_COUNT     = 6,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               prog_wr_en,
    input  logic [PADDR_W-1:0] prog_wr_addr,
    input  logic [DATA_W-1:0]  prog_wr_data,
    input  logic [PADDR_W:0]   prog_len,
    input  logic               start,
    output logic               mem_wr_en,
    output logic [PADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0]  mem_wr_data,
    output logic               reg_wr_en,
    output logic [RADDR_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0]  reg_wr_data,
    output logic               cpu_clear,
    output logic               cpu_run,
    input  logic               cpu_halted,
    output logic [RADDR_W-1:0] reg_rd_addr,
    input  logic [DATA_W-1:0]  reg_rd_data,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [RADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0]  dump_data,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   run_cycles
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INIT, S_CLEAR, S_RUN, S_DREQ, S_DOUT, S_DONE
    } state_t;

    localparam int CW  = ((PADDR_W > RADDR_W) ? PADDR_W : RADDR_W) + 1;
    localparam int PLW = PADDR_W + 1;
    localparam logic [PADDR_W:0] DEPTH_L = PLW'(PROG_DEPTH);

    state_t              state, state_next, after_load;
    logic [DATA_W-1:0]   prog_buf [PROG_DEPTH];
    logic [PADDR_W:0]    len, len_clamped;
    logic [CW-1:0]       cnt;
    logic [CNT_W-1:0]    rc_inc;
    logic                idle_like, last_load, last_init, last_dump, tmo_hit;

    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_load   = (cnt + CW'(1)) == CW'(len);
    assign last_init   = cnt == CW'(REG_COUNT - 1);
    assign last_dump   = cnt == CW'(DUMP_COUNT - 1);
    assign rc_inc      = (run_cycles == '1) ? run_cycles : run_cycles + CNT_W'(1);
    assign tmo_hit     = rc_inc >= CNT_W'(TIMEOUT_CYCLES);
    assign after_load  = (INIT_REGS != 0) ? S_INIT : S_CLEAR;
    assign busy        = !idle_like;
    assign done        = (state == S_DONE);

    // Host writes only land while the core is not being fed, so a running load never sees a torn buffer.
    always_ff @(posedge clk1) begin
        if (prog_wr_en && idle_like) begin
            prog_buf[prog_wr_addr] <= prog_wr_data;
        end
    end

    always_comb begin
        state_next  = state;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        cpu_clear   = 1'b0;
        cpu_run     = 1'b0;
        reg_rd_addr = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? after_load : S_LOAD;
                end
            end
            S_LOAD: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = cnt[PADDR_W-1:0];
                mem_wr_data = prog_buf[cnt[PADDR_W-1:0]];
                if (last_load) state_next = after_load;
            end
            S_INIT: begin
                reg_wr_en   = 1'b1;
                reg_wr_addr = cnt[RADDR_W-1:0];
                reg_wr_data = DATA_W'(cnt[RADDR_W-1:0]);
                if (last_init) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                cpu_clear  = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                if (cpu_halted || tmo_hit) state_next = S_DREQ;
            end
            S_DREQ: begin
                reg_rd_addr = cnt[RADDR_W-1:0];
                state_next  = S_DOUT;
            end
            S_DOUT: begin
                reg_rd_addr = cnt[RADDR_W-1:0];
                if (dump_valid && dump_ready) state_next = last_dump ? S_DONE : S_DREQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Dump port: a word transfers on any rising edge where dump_valid && dump_ready;
    // once dump_valid rises, dump_idx/dump_data hold until that transfer.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            cnt        <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len        <= len_clamped;
                        cnt        <= '0;
                        run_cycles <= '0;
                        timeout    <= 1'b0;
                    end
                end
                S_LOAD: cnt <= last_load ? '0 : cnt + CW'(1);
                S_INIT: cnt <= last_init ? '0 : cnt + CW'(1);
                S_RUN: begin
                    run_cycles <= rc_inc;
                    if (!cpu_halted && tmo_hit) timeout <= 1'b1;
                end
                // Read data arrives one cycle after the address, so the first DOUT cycle captures it.
                S_DOUT: begin
                    if (!dump_valid) begin
                        dump_valid <= 1'b1;
                        dump_data  <= reg_rd_data;
                        dump_idx   <= cnt[RADDR_W-1:0];
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        cnt        <= last_dump ? '0 : cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_test_harness.sv
// Directed bench: two harness instances, one driving a small behavioural MIPS core,
// the other (INIT_REGS=0, DUMP_COUNT=2) a stub core used for clamping and skip checks.
module tb_mips_test_harness;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst = 1'b1;
    logic        prog_wr_en = 1'b0;
    logic [3:0]  prog_wr_addr = '0;
    logic [31:0] prog_wr_data = '0;
    logic [4:0]  prog_len = '0;
    logic [4:0]  prog_len_b = '0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        dump_ready = 1'b1;

    logic        mem_wr_en, reg_wr_en, cpu_clear, cpu_run, cpu_halted, dump_valid, busy, done, timeout;
    logic [3:0]  mem_wr_addr;
    logic [4:0]  reg_wr_addr, reg_rd_addr, dump_idx;
    logic [31:0] mem_wr_data, reg_wr_data, reg_rd_data, dump_data;
    logic [15:0] run_cycles;

    logic        mem_wr_en_b, reg_wr_en_b, cpu_clear_b, cpu_run_b, dump_valid_b, busy_b, done_b, timeout_b;
    logic [3:0]  mem_wr_addr_b;
    logic [4:0]  reg_wr_addr_b, reg_rd_addr_b, dump_idx_b;
    logic [31:0] mem_wr_data_b, reg_wr_data_b, reg_rd_data_b, dump_data_b;
    logic [15:0] run_cycles_b;

    mips_test_harness #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk1(clk1), .rst(rst), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
        .prog_wr_data(prog_wr_data), .prog_len(prog_len), .start(start),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .cpu_clear(cpu_clear), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
    );

    mips_test_harness #(.INIT_REGS(0), .DUMP_COUNT(2)) u_dut_b (
        .clk1(clk1), .rst(rst), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
        .prog_wr_data(prog_wr_data), .prog_len(prog_len_b), .start(start_b),
        .mem_wr_en(mem_wr_en_b), .mem_wr_addr(mem_wr_addr_b), .mem_wr_data(mem_wr_data_b),
        .reg_wr_en(reg_wr_en_b), .reg_wr_addr(reg_wr_addr_b), .reg_wr_data(reg_wr_data_b),
        .cpu_clear(cpu_clear_b), .cpu_run(cpu_run_b), .cpu_halted(1'b1),
        .reg_rd_addr(reg_rd_addr_b), .reg_rd_data(reg_rd_data_b), .dump_valid(dump_valid_b),
        .dump_ready(1'b1), .dump_idx(dump_idx_b), .dump_data(dump_data_b),
        .busy(busy_b), .done(done_b), .timeout(timeout_b), .run_cycles(run_cycles_b)
    );

    wire [138:0] out_a = {mem_wr_en, mem_wr_addr, mem_wr_data, reg_wr_en, reg_wr_addr, reg_wr_data,
                          cpu_clear, cpu_run, reg_rd_addr, dump_valid, dump_idx, dump_data,
                          busy, done, timeout, run_cycles};
    wire [138:0] out_b = {mem_wr_en_b, mem_wr_addr_b, mem_wr_data_b, reg_wr_en_b, reg_wr_addr_b, reg_wr_data_b,
                          cpu_clear_b, cpu_run_b, reg_rd_addr_b, dump_valid_b, dump_idx_b, dump_data_b,
                          busy_b, done_b, timeout_b, run_cycles_b};

    // Behavioural core: one instruction per enabled cycle, registered register-file read.
    logic [31:0] imem [16];
    logic [31:0] regs [32];
    logic [3:0]  pc = '0;
    logic        halted = 1'b0;
    logic [1:0]  halt_mode = 2'd0;
    int          run_cnt = 0;
    logic [31:0] instr;
    assign instr = imem[pc];
    assign cpu_halted = (halt_mode == 2'd0) ? halted : (halt_mode == 2'd2 && cpu_run && run_cnt == 15);

    always @(posedge clk1) begin
        if (mem_wr_en) imem[mem_wr_addr] <= mem_wr_data;
        if (reg_wr_en) regs[reg_wr_addr] <= reg_wr_data;
        reg_rd_data <= regs[reg_rd_addr];
        run_cnt <= cpu_run ? run_cnt + 1 : 0;
        if (cpu_clear) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (cpu_run && !halted) begin
            pc <= pc + 4'd1;
            case (instr[31:26])
                6'h00: regs[instr[15:11]] <= regs[instr[25:21]] + regs[instr[20:16]];
                6'h03: regs[instr[15:11]] <= regs[instr[25:21]] | regs[instr[20:16]];
                6'h0a: regs[instr[20:16]] <= regs[instr[25:21]] + {{16{instr[15]}}, instr[15:0]};
                6'h3f: halted <= 1'b1;
                default: ;
            endcase
        end
    end

    always @(posedge clk1) reg_rd_data_b <= {27'h0, reg_rd_addr_b};

    // Event monitors
    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          mem_cnt, mem_err, mem_first, mem_last, reg_cnt, reg_err, reg_last;
    int          clr_cnt, clr_cyc, run_hi, acc_total;
    int          acc_cnt [6];
    logic [31:0] seen_mem [16];
    int          b_mem_cnt, b_mem_last, b_reg_cnt, b_clr_cyc, b_acc;
    logic [31:0] b_last_data;

    always @(posedge clk1) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            mem_cnt <= 0; mem_err <= 0; mem_first <= 0; mem_last <= 0;
            reg_cnt <= 0; reg_err <= 0; reg_last <= 0;
            clr_cnt <= 0; clr_cyc <= 0; run_hi <= 0; acc_total <= 0;
            for (int k = 0; k < 6; k++) acc_cnt[k] <= 0;
            b_mem_cnt <= 0; b_mem_last <= 0; b_reg_cnt <= 0; b_clr_cyc <= 0; b_acc <= 0;
            b_last_data <= '0;
        end else begin
            if (mem_wr_en) begin
                if (mem_cnt == 0) mem_first <= cyc;
                mem_last <= cyc;
                if (int'(mem_wr_addr) != mem_cnt) mem_err <= mem_err + 1;
                seen_mem[mem_wr_addr] <= mem_wr_data;
                mem_cnt <= mem_cnt + 1;
            end
            if (reg_wr_en) begin
                if (int'(reg_wr_addr) != reg_cnt || reg_wr_data != 32'(reg_cnt)) reg_err <= reg_err + 1;
                reg_last <= cyc;
                reg_cnt  <= reg_cnt + 1;
            end
            if (cpu_clear) begin
                clr_cnt <= clr_cnt + 1;
                clr_cyc <= cyc;
            end
            if (cpu_run) run_hi <= run_hi + 1;
            if (dump_valid && dump_ready) begin
                acc_total <= acc_total + 1;
                if (dump_idx < 5'd6) acc_cnt[dump_idx] <= acc_cnt[dump_idx] + 1;
            end
            if (mem_wr_en_b) begin
                b_mem_cnt  <= b_mem_cnt + 1;
                b_mem_last <= cyc;
            end
            if (reg_wr_en_b) b_reg_cnt <= b_reg_cnt + 1;
            if (cpu_clear_b) b_clr_cyc <= cyc;
            if (dump_valid_b) begin
                b_acc       <= b_acc + 1;
                b_last_data <= dump_data_b;
            end
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [4:0] len);
        mon_clr = 1'b1;
        @(negedge clk1);
        mon_clr  = 1'b0;
        prog_len = len;
        start    = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!cpu_run && n < 200) begin
            @(negedge clk1);
            n++;
        end
        check("run_wait", 32'(cpu_run), 32'd1);
    endtask

    // Collects R0..R5 in order; optionally holds dump_ready low for 3 cycles on one word.
    task automatic drain(input int stall_idx);
        logic [31:0] expv;
        int n;
        exp_q = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
        for (int w = 0; w < 6; w++) begin
            n = 0;
            while (!dump_valid && n < 400) begin
                @(negedge clk1);
                n++;
            end
            check("dump_wait", 32'(dump_valid), 32'd1);
            expv = exp_q.pop_front();
            if (dump_valid) begin
                check("dump_idx", 32'(dump_idx), 32'(w));
                check("dump_data", dump_data, expv);
                if (w == stall_idx) begin
                    dump_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk1);
                        check("stall_valid", 32'(dump_valid), 32'd1);
                        check("stall_idx", 32'(dump_idx), 32'(w));
                        check("stall_data", dump_data, expv);
                    end
                    dump_ready = 1'b1;
                end
                @(negedge clk1);
            end
        end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk1);
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("acc_total", 32'(acc_total), 32'd6);
    endtask

    initial begin
        int n;
        // Reset
        repeat (3) @(negedge clk1);
        check("rst_outs_a", 32'(|out_a), 32'd0);
        check("rst_outs_b", 32'(|out_b), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            prog_wr_en   = 1'b1;
            prog_wr_addr = 4'(i);
            prog_wr_data = (i < 9) ? prog[i] : 32'hfc000000;
            @(negedge clk1);
        end
        prog_wr_en = 1'b0;

        // Clamp and INIT skip on the second instance
        mon_clr = 1'b1;
        @(negedge clk1);
        mon_clr    = 1'b0;
        prog_len_b = 5'd20;
        start_b    = 1'b1;
        @(negedge clk1);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin
            @(negedge clk1);
            n++;
        end
        check("b_done", 32'(done_b), 32'd1);
        check("b_mem_cnt", 32'(b_mem_cnt), 32'd16);
        check("b_reg_cnt", 32'(b_reg_cnt), 32'd0);
        check("b_clear_after_load", 32'(b_clr_cyc - b_mem_last), 32'd1);
        check("b_dump_cnt", 32'(b_acc), 32'd2);
        check("b_last_data", b_last_data, 32'd1);

        // Normal program run ending in HLT
        start_run(5'd9);
        drain(99);
        check("mem_cnt", 32'(mem_cnt), 32'd9);
        check("mem_span", 32'(mem_last - mem_first), 32'd8);
        check("mem_order", 32'(mem_err), 32'd0);
        for (int i = 0; i < 9; i++) check("mem_data", seen_mem[i], prog[i]);
        check("reg_cnt", 32'(reg_cnt), 32'd32);
        check("reg_vals", 32'(reg_err), 32'd0);
        check("clr_cnt", 32'(clr_cnt), 32'd1);
        check("clear_after_init", 32'(clr_cyc - reg_last), 32'd1);
        check("run_hi_hlt", 32'(run_hi), 32'd10);
        check("run_cycles_hlt", 32'(run_cycles), 32'd10);
        check("timeout_hlt", 32'(timeout), 32'd0);

        // Backpressure on word 2
        start_run(5'd9);
        drain(2);
        for (int k = 0; k < 6; k++) check("idx_once", 32'(acc_cnt[k]), 32'd1);

        // Timeout with halt never seen
        halt_mode = 2'd1;
        start_run(5'd9);
        drain(99);
        check("run_hi_tmo", 32'(run_hi), 32'd16);
        check("timeout_tmo", 32'(timeout), 32'd1);
        check("run_cycles_tmo", 32'(run_cycles), 32'd16);

        // Halt on the same cycle as the timeout; start clears previous status
        halt_mode = 2'd2;
        start_run(5'd9);
        check("start_clr_timeout", 32'(timeout), 32'd0);
        check("start_clr_cycles", 32'(run_cycles), 32'd0);
        drain(99);
        check("run_hi_tie", 32'(run_hi), 32'd16);
        check("timeout_tie", 32'(timeout), 32'd0);
        check("run_cycles_tie", 32'(run_cycles), 32'd16);

        // start in LOAD and RUN, buffer write in RUN: all ignored
        halt_mode = 2'd0;
        start_run(5'd9);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        wait_run();
        start        = 1'b1;
        prog_wr_en   = 1'b1;
        prog_wr_addr = 4'd0;
        prog_wr_data = 32'hdeadbeef;
        @(negedge clk1);
        start      = 1'b0;
        prog_wr_en = 1'b0;
        drain(99);
        check("ign_mem_cnt", 32'(mem_cnt), 32'd9);
        check("ign_clr_cnt", 32'(clr_cnt), 32'd1);
        check("ign_run_hi", 32'(run_hi), 32'd10);

        // Reset mid-RUN, then reload
        start_run(5'd9);
        wait_run();
        repeat (3) @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        check("midrun_rst_outs", 32'(|out_a), 32'd0);
        check("midrun_cpu_run", 32'(cpu_run), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk1);
        check("midrun_no_dump", 32'(acc_total), 32'd0);
        check("midrun_idle", 32'(busy), 32'd0);
        start_run(5'd9);
        drain(99);
        for (int i = 0; i < 9; i++) check("reload_data", seen_mem[i], prog[i]);
        check("reload_run_hi", 32'(run_hi), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
